rtsnoc_port_arbiter: RTL

RTSNOC_PORT_ARBITER -- requirements
Module: rtsnoc_port_arbiter

---
 rtl/rtsnoc_pkg.sv | 27 ++
 rtl/rtsnoc_rr_arbiter.sv | 37 +++
 rtl/rtsnoc_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rtsnoc_pkg.sv
// Shared flit geometry and FSM encodings for the RTSNoC local-port arbiter.
// Flit layout (LSB first): payload, local destination field, remaining header.
package rtsnoc_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_ISSUE = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_GAP  = 1'b1
    } rx_state_t;

    localparam int HDR_FLAG_BITS = 6;
    localparam int DST_BITS      = 2;

    function automatic int bus_width(input int data_w, input int size_x, input int size_y);
        return data_w + 2 * size_x + 2 * size_y + HDR_FLAG_BITS;
    endfunction

    // The local destination field sits immediately above the payload.
    function automatic int dst_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/rtsnoc_rr_arbiter.sv
// Round-robin pick: first requester after last_grant, wrapping modulo N.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the grant is taken.
module rtsnoc_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last_grant,
    output logic [N-1:0] grant,
    output logic [1:0]   grant_idx
);

    logic       found;
    logic [2:0] sum;
    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last_grant} + 3'(k);
            if (sum >= 3'(N)) begin
                sum = sum - 3'(N);
            end
            idx = sum[1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rtsnoc_port_arbiter.sv
// Multiplexes up to 4 clients onto one NoC router local port and demuxes RX flits.
// Latency: TX req->wr 1 cycle (2 cycles/flit); RX nd->rd 0 cycles, client valid next cycle.
// Backpressure: TX holds while noc_wait_i; RX withholds noc_rd_o while the target buffer is full.
module rtsnoc_port_arbiter
    import rtsnoc_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 32,
    localparam int BUS           = bus_width(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_CLIENTS-1:0]     cl_tx_req_i,
    input  logic [NUM_CLIENTS*BUS-1:0] cl_tx_data_i,
    output logic [NUM_CLIENTS-1:0]     cl_tx_ack_o,
    output logic [NUM_CLIENTS-1:0]     cl_rx_valid_o,
    output logic [NUM_CLIENTS*BUS-1:0] cl_rx_data_o,
    input  logic [NUM_CLIENTS-1:0]     cl_rx_ready_i,
    output logic [BUS-1:0]             noc_din_o,
    output logic                       noc_wr_o,
    input  logic                       noc_wait_i,
    input  logic [BUS-1:0]             noc_dout_i,
    input  logic                       noc_nd_i,
    output logic                       noc_rd_o,
    output logic [7:0]                 drop_cnt_o
);

    localparam int DST_LSB = dst_lsb(NOC_DATA_WIDTH);

    // Reset assertion is immediate; release must pass two flops before the FSMs may move.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    // ---------------- TX ----------------
    tx_state_t              tx_state_q, tx_state_d;
    logic [1:0]             last_grant_q;
    logic [NUM_CLIENTS-1:0] arb_grant;
    logic [1:0]             arb_idx;
    logic                   tx_load;
    logic [BUS-1:0]         sel_dat;

    rtsnoc_rr_arbiter #(
        .N (NUM_CLIENTS)
    ) u_rr (
        .req        (cl_tx_req_i),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_grant[i]) begin
                sel_dat = sel_dat | cl_tx_data_i[i*BUS +: BUS];
            end
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_load     = 1'b0;
        noc_wr_o    = 1'b0;
        cl_tx_ack_o = '0;
        case (tx_state_q)
            TX_IDLE: begin
                if (run && |cl_tx_req_i) begin
                    tx_load    = 1'b1;
                    tx_state_d = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                if (!noc_wait_i) begin
                    noc_wr_o                  = 1'b1;
                    cl_tx_ack_o[last_grant_q] = 1'b1;
                    tx_state_d                = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // last_grant doubles as the in-flight owner while in TX_ISSUE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q   <= TX_IDLE;
            last_grant_q <= 2'(NUM_CLIENTS - 1);
            noc_din_o    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_load) begin
                last_grant_q <= arb_idx;
                noc_din_o    <= sel_dat;
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t              rx_state_q, rx_state_d;
    logic [1:0]             dst;
    logic                   dst_bad;
    logic                   dst_free;
    logic                   capture;
    logic [NUM_CLIENTS-1:0] consume;

    assign dst     = noc_dout_i[DST_LSB +: DST_BITS];
    assign dst_bad = ({1'b0, dst} >= 3'(NUM_CLIENTS));
    assign consume = cl_rx_valid_o & cl_rx_ready_i;

    always_comb begin
        dst_free = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (dst == 2'(i)) begin
                dst_free = !cl_rx_valid_o[i] || consume[i];
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        noc_rd_o   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (run && noc_nd_i && (dst_bad || dst_free)) begin
                    noc_rd_o   = 1'b1;
                    rx_state_d = RX_GAP;
                end
            end
            RX_GAP:  rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign capture = noc_rd_o && !dst_bad;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state_q    <= RX_IDLE;
            cl_rx_valid_o <= '0;
            cl_rx_data_o  <= '0;
            drop_cnt_o    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                // A refill in the same cycle as a consume keeps valid high.
                if (capture && dst == 2'(i)) begin
                    cl_rx_valid_o[i]            <= 1'b1;
                    cl_rx_data_o[i*BUS +: BUS] <= noc_dout_i;
                end else if (consume[i]) begin
                    cl_rx_valid_o[i] <= 1'b0;
                end
            end
            if (noc_rd_o && dst_bad && drop_cnt_o != 8'hFF) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

endmodule
